pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and flow controller for a classic 5-stage in-order pipeline.
//   It detects load-use hazards, applies branch redirects, stalls on slow
//   data memory, and sequences halt/drain/resume.
//   Outputs are decoded combinationally from the current state and inputs.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs*   source operands of the instruction in ID
//   ex_rd, ex_mem_read           destination and load flag of the EX instruction
//   branch_taken                 EX resolved a redirect
//   imem_ready                   fetch data valid this cycle
//   mem_access, dmem_ready       MEM stage data access and its completion
//   halt_req, resume             halt request from ID; resume pulse
//   *_enable                     pipeline register enables
//   if_id_flush, id_ex_flush     insert a bubble into IF/ID or ID/EX
//   halted                       core is parked in HALTED
//   stall_cycles, flush_count    saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StInit,
    StRun,
    StDmemWait,
    StDrain,
    StHalted
  } state_e;

  state_e             state_q, state_d;
  logic               from_drain_q, from_drain_d;
  logic [DrainW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic       load_use;
  logic       dmem_stall;
  logic       redirect;
  logic [4:0] en; // {pc, if_id, id_ex, ex_mem, mem_wb}

  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign dmem_stall = mem_access & ~dmem_ready;

  always_comb begin
    state_d      = state_q;
    from_drain_d = from_drain_q;
    drain_cnt_d  = drain_cnt_q;
    en           = 5'b00000;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    halted       = 1'b0;
    redirect     = 1'b0;

    unique case (state_q)
      StInit: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = StRun;
      end

      StRun: begin
        if (dmem_stall) begin
          state_d      = StDmemWait;
          from_drain_d = 1'b0;
        end else if (branch_taken) begin
          // Redirect wins; a coincident load-use or halt belongs to a squashed instruction.
          en          = 5'b11111;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          redirect    = 1'b1;
        end else if (load_use) begin
          en          = 5'b00111;
          id_ex_flush = 1'b1;
        end else if (halt_req) begin
          en          = 5'b01111;
          if_id_flush = 1'b1;
          drain_cnt_d = DrainLoad;
          state_d     = StDrain;
        end else if (!imem_ready) begin
          en          = 5'b01111;
          if_id_flush = 1'b1;
        end else begin
          en = 5'b11111;
        end
      end

      StDmemWait: begin
        if (dmem_ready) begin
          en = 5'b11111;
          if (from_drain_q) begin
            // The completing cycle advances the pipeline, so it counts as a drain step.
            state_d = StDrain;
            if (drain_cnt_q != '0) begin
              drain_cnt_d = drain_cnt_q - 1'b1;
            end
          end else begin
            state_d = StRun;
          end
        end
      end

      StDrain: begin
        if (dmem_stall) begin
          state_d      = StDmemWait;
          from_drain_d = 1'b1;
        end else begin
          en          = 5'b01111;
          if_id_flush = 1'b1;
          if (drain_cnt_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
      end

      StHalted: begin
        halted = 1'b1;
        if (resume) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign pc_enable     = en[4];
  assign if_id_enable  = en[3];
  assign id_ex_enable  = en[2];
  assign ex_mem_enable = en[1];
  assign mem_wb_enable = en[0];

  // Saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!en[4] && (state_q != StInit) && (state_q != StHalted) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (redirect && (flush_q != '1)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StInit;
      from_drain_q <= 1'b0;
      drain_cnt_q  <= '0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      from_drain_q <= from_drain_d;
      drain_cnt_q  <= drain_cnt_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a rule-level model predicts
// every output each cycle; directed scenarios pin the model with literals.
// Two instances share stimulus: 16-bit and 4-bit counters.
module tb_pipeline_hazard_ctrl;

  logic       clk, resetn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, imem_ready;
  logic       mem_access, dmem_ready, halt_req, resume;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, hlt;
  logic [15:0] stall16, flush16;
  logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_fl4, idex_fl4, hlt4;
  logic [3:0]  stall4, flush4;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume),
    .pc_enable(pc_en), .if_id_enable(ifid_en), .id_ex_enable(idex_en),
    .ex_mem_enable(exmem_en), .mem_wb_enable(memwb_en), .if_id_flush(ifid_fl),
    .id_ex_flush(idex_fl), .halted(hlt), .stall_cycles(stall16), .flush_count(flush16)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume),
    .pc_enable(pc_en4), .if_id_enable(ifid_en4), .id_ex_enable(idex_en4),
    .ex_mem_enable(exmem_en4), .mem_wb_enable(memwb_en4), .if_id_flush(ifid_fl4),
    .id_ex_flush(idex_fl4), .halted(hlt4), .stall_cycles(stall4), .flush_count(flush4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control bundle: {halted, pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [7:0] PInit     = 8'b0_00000_11;
  localparam logic [7:0] PFreeze   = 8'b0_00000_00;
  localparam logic [7:0] PRedirect = 8'b0_11111_11;
  localparam logic [7:0] PLoadUse  = 8'b0_00111_01;
  localparam logic [7:0] PBubble   = 8'b0_01111_10;
  localparam logic [7:0] PGo       = 8'b0_11111_00;
  localparam logic [7:0] PHalted   = 8'b1_00000_00;

  logic [7:0] ctrl, ctrl4;
  assign ctrl  = {hlt, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl};
  assign ctrl4 = {hlt4, pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_fl4, idex_fl4};

  // ---------------- reference model ----------------
  typedef enum int {MInit, MRun, MWait, MDrain, MHalt} mode_e;

  mode_e      m_mode, m_mode_nx;
  bit         m_ret, m_ret_nx;     // stall started while draining
  int         m_left, m_left_nx;   // drain steps still owed after the current one
  int         m_stalls, m_flushes; // unbounded event counts
  logic [7:0] exp_ctrl;
  bit         m_redirect;

  always_comb begin
    bit lu, frz;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    frz = mem_access && !dmem_ready;
    m_mode_nx  = m_mode;
    m_ret_nx   = m_ret;
    m_left_nx  = m_left;
    m_redirect = 1'b0;
    exp_ctrl   = PFreeze;
    case (m_mode)
      MInit: begin exp_ctrl = PInit; m_mode_nx = MRun; end
      MRun: begin
        if (frz) begin m_mode_nx = MWait; m_ret_nx = 1'b0; end
        else if (branch_taken) begin exp_ctrl = PRedirect; m_redirect = 1'b1; end
        else if (lu) exp_ctrl = PLoadUse;
        else if (halt_req) begin exp_ctrl = PBubble; m_left_nx = 2; m_mode_nx = MDrain; end
        else if (!imem_ready) exp_ctrl = PBubble;
        else exp_ctrl = PGo;
      end
      MWait: begin
        if (dmem_ready) begin
          exp_ctrl  = PGo;
          m_mode_nx = m_ret ? MDrain : MRun;
          if (m_ret && m_left > 0) m_left_nx = m_left - 1;
        end
      end
      MDrain: begin
        if (frz) begin m_mode_nx = MWait; m_ret_nx = 1'b1; end
        else begin
          exp_ctrl = PBubble;
          if (m_left == 0) m_mode_nx = MHalt;
          else m_left_nx = m_left - 1;
        end
      end
      default: begin exp_ctrl = PHalted; if (resume) m_mode_nx = MRun; end
    endcase
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode <= MInit; m_ret <= 1'b0; m_left <= 0; m_stalls <= 0; m_flushes <= 0;
    end else begin
      m_mode <= m_mode_nx; m_ret <= m_ret_nx; m_left <= m_left_nx;
      if (!exp_ctrl[6] && m_mode != MInit && m_mode != MHalt) m_stalls <= m_stalls + 1;
      if (m_redirect) m_flushes <= m_flushes + 1;
    end
  end

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One comparison of every output per cycle, away from the rising edge.
  always @(negedge clk) begin
    check("ctrl16", {24'd0, ctrl}, {24'd0, exp_ctrl});
    check("ctrl4", {24'd0, ctrl4}, {24'd0, exp_ctrl});
    check("stall16", 32'(stall16), sat(m_stalls, 65535));
    check("flush16", 32'(flush16), sat(m_flushes, 65535));
    check("stall4", 32'(stall4), sat(m_stalls, 15));
    check("flush4", 32'(flush4), sat(m_flushes, 15));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
    imem_ready = 1'b1; mem_access = 1'b0; dmem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  // Leaves the bench 1 ns after the edge that moves INIT -> RUN.
  task automatic do_reset();
    step();
    resetn = 1'b0;
    idle();
    #1;
    check("rst_ctrl", {24'd0, ctrl}, {24'd0, PInit});
    check("rst_stall", 32'(stall16), 32'd0);
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int gap;
    resetn = 1'b0;
    idle();

    // Load-use: one stall cycle.
    do_reset();
    check("run_after_reset", {24'd0, ctrl}, {24'd0, PGo});
    set_load_use();
    settle();
    check("lu_ctrl", {24'd0, ctrl}, {24'd0, 8'b0_00111_01});
    step();
    idle();
    settle();
    check("lu_stall_cnt", 32'(stall16), 32'd1);

    // Redirect beats load-use.
    do_reset();
    set_load_use();
    branch_taken = 1'b1;
    settle();
    check("br_ctrl", {24'd0, ctrl}, {24'd0, 8'b0_11111_11});
    step();
    idle();
    settle();
    check("br_flush_cnt", 32'(flush16), 32'd1);
    check("br_stall_cnt", 32'(stall16), 32'd0);

    // Four cycles of data memory wait.
    do_reset();
    mem_access = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("dmem_frozen", {27'd0, ctrl[6:2]}, 32'd0);
      step();
    end
    dmem_ready = 1'b1;
    settle();
    check("dmem_release", {27'd0, ctrl[6:2]}, 32'h1f);
    step();
    idle();
    settle();
    check("dmem_back_run", {24'd0, ctrl}, {24'd0, PGo});
    check("dmem_stall_cnt", 32'(stall16), 32'd4);

    // Halt with two dmem-stall cycles inside the drain: five cycles pass before halted.
    do_reset();
    halt_req = 1'b1;
    settle();
    check("halt_ctrl", {24'd0, ctrl}, {24'd0, 8'b0_01111_10});
    step();
    idle();
    gap = 0;
    while (gap < 20) begin
      mem_access = (gap < 2);
      dmem_ready = !(gap < 2);
      settle();
      if (hlt) break;
      gap++;
      step();
    end
    idle();
    check("drain_gap", 32'(gap), 32'd5);
    resume = 1'b1;
    step();
    resume = 1'b0;
    settle();
    check("resume_run", {24'd0, ctrl}, {24'd0, PGo});

    // Asynchronous reset in the middle of a drain.
    do_reset();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("pre_rst_stall", 32'(stall16), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_ctrl", {24'd0, ctrl}, {24'd0, PInit});
    check("mid_rst_stall", 32'(stall16), 32'd0);
    step();
    resetn = 1'b1;
    step();
    settle();
    check("mid_rst_run", {24'd0, ctrl}, {24'd0, PGo});

    // Twenty separate load-use stalls saturate the 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_load_use();
      step();
      idle();
      step();
    end
    settle();
    check("sat_stall4", 32'(stall4), 32'd15);
    check("sat_stall16", 32'(stall16), 32'd20);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      resetn       = ($urandom_range(0, 599) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom_range(0, 1));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      imem_ready   = ($urandom_range(0, 7) != 0);
      mem_access   = ($urandom_range(0, 3) == 0);
      dmem_ready   = ($urandom_range(0, 1) == 0);
      halt_req     = ($urandom_range(0, 15) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      step();
    end
    resetn = 1'b1;
    idle();
    step();
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
